du_param_core: RTL and testbench

Parametrised successor to the 8-bit scalar data unit. It provides an N-entry register file, a program counter (PC), an instruction register (IR), a flag register and an add/sub/logic ALU. Memory access uses a valid/ack handshake with split read and write data buses; there is no tri-state bus. It sits between the control unit, which issues one micro-op command at a time, and the memory/bus fabric.

---
 rtl/du_pkg.sv | 39 +++
 rtl/du_alu.sv | 47 ++++
 rtl/du_param_core.sv | 187 ++++++++++++++++++
 tb/tb_du_param_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/du_pkg.sv
// rtl/du_pkg.sv - shared op codes, FSM states and flag indices for the data unit
package du_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_COPY  = 4'd1,
        OP_LDI   = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_LOAD  = 4'd8,
        OP_STORE = 4'd9,
        OP_FETCH = 4'd10,
        OP_JUMP  = 4'd11,
        OP_CFR   = 4'd12,
        OP_ADC   = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int FLG_Z = 3;
    localparam int FLG_S = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Ops that need a memory transfer before they can complete
    function automatic logic is_bus_op(input op_e op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_FETCH);
    endfunction

endpackage

// File: rtl/du_alu.sv
// rtl/du_alu.sv - combinational add/sub/adc/logic unit with {Z,S,C,V} flags
module du_alu
    import du_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  op_e               op,
    output logic [DATA_W-1:0] y,
    output logic [3:0]        flg
);

    logic [DATA_W-1:0] b_eff;
    logic              c_eff;
    logic [DATA_W:0]   sum;
    logic              carry;
    logic              ovf;

    // One adder serves ADD/SUB/ADC; SUB feeds ~b with carry-in 1 so C=1 means no borrow
    always_comb begin
        b_eff = b;
        c_eff = 1'b0;
        case (op)
            OP_SUB:  begin b_eff = ~b; c_eff = 1'b1; end
            OP_ADC:  c_eff = cin;
            default: ;
        endcase
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, c_eff};
        y     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        ovf   = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        case (op)
            OP_AND:  begin y = a & b; carry = 1'b0; ovf = 1'b0; end
            OP_OR:   begin y = a | b; carry = 1'b0; ovf = 1'b0; end
            OP_XOR:  begin y = a ^ b; carry = 1'b0; ovf = 1'b0; end
            default: ;
        endcase
        flg        = 4'b0000;
        flg[FLG_Z] = (y == '0);
        flg[FLG_S] = y[DATA_W-1];
        flg[FLG_C] = carry;
        flg[FLG_V] = ovf;
    end

endmodule

// File: rtl/du_param_core.sv
// rtl/du_param_core.sv - parametrised data unit core; DU_BUS_TIMEOUT_EN enables the bus watchdog
module du_param_core
    import du_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int NREG        = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rs1,
    input  logic [$clog2(NREG)-1:0] cmd_rs2,
    input  logic [DATA_W-1:0]       cmd_imm,
    output logic                    done,
    output logic                    err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack,
    output logic [ADDR_W-1:0]       pc,
    output logic [DATA_W-1:0]       ir,
    output logic [3:0]              flags,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [DATA_W-1:0]       dbg_data
);

    localparam int RW = $clog2(NREG);
    localparam int AC = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

    state_e            state, state_d;
    op_e               op_in, bus_op;
    logic [RW-1:0]     bus_rd;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rs1_val, rs2_val, alu_y, cfr_val;
    logic [3:0]        alu_flg;
    logic              err_q;
    logic              accept, bus_done, timeout;

    // Register value used as an address: low bits, zero-extended when narrower
    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
        logic [ADDR_W-1:0] a;
        a         = '0;
        a[AC-1:0] = v[AC-1:0];
        return a;
    endfunction

    assign op_in    = op_e'(cmd_op);
    assign rs1_val  = regs[cmd_rs1];
    assign rs2_val  = regs[cmd_rs2];
    assign dbg_data = regs[dbg_sel];
    assign accept   = (state == ST_IDLE) && cmd_valid;
    assign bus_done = (state == ST_BUS) && mem_ack;

    // Flag register zero-extended into a data word for CFR
    always_comb begin
        cfr_val      = '0;
        cfr_val[3:0] = flags;
    end

    du_alu #(.DATA_W(DATA_W)) u_alu (
        .a   (rs1_val),
        .b   (rs2_val),
        .cin (flags[FLG_C]),
        .op  (op_in),
        .y   (alu_y),
        .flg (alu_flg)
    );

`ifdef DU_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts consecutive unacknowledged request cycles, restarting on every entry to BUS
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != ST_BUS)
            tmo_cnt <= '0;
        else if (!mem_ack)
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign timeout = (state == ST_BUS) && !mem_ack && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register; reset returns to IDLE so mem_req drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        mem_req   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = is_bus_op(op_in) ? ST_BUS : ST_RESP;
            end
            ST_BUS: begin
                mem_req = 1'b1;
                if (mem_ack || timeout)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: register ops retire at accept, bus ops latch the transfer then retire on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            pc        <= '0;
            ir        <= '0;
            flags     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            bus_op    <= OP_NOP;
            bus_rd    <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            err_q  <= 1'b0;
            bus_op <= op_in;
            bus_rd <= cmd_rd;
            case (op_in)
                OP_COPY: regs[cmd_rd] <= rs1_val;
                OP_LDI:  regs[cmd_rd] <= cmd_imm;
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC: begin
                    regs[cmd_rd] <= alu_y;
                    flags        <= alu_flg;
                end
                OP_LOAD: begin
                    mem_addr <= to_addr(rs1_val);
                    mem_we   <= 1'b0;
                end
                OP_STORE: begin
                    mem_addr  <= to_addr(rs1_val);
                    mem_wdata <= rs2_val;
                    mem_we    <= 1'b1;
                end
                OP_FETCH: begin
                    mem_addr <= pc;
                    mem_we   <= 1'b0;
                end
                OP_JUMP:            pc           <= to_addr(rs1_val);
                OP_CFR:             regs[cmd_rd] <= cfr_val;
                OP_ILL14, OP_ILL15: err_q        <= 1'b1;
                default: ;
            endcase
        end else if (bus_done) begin
            case (bus_op)
                OP_LOAD: regs[bus_rd] <= mem_rdata;
                OP_FETCH: begin
                    ir <= mem_rdata;
                    pc <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_du_param_core.sv
// tb/tb_du_param_core.sv - self-checking bench for du_param_core
`timescale 1ns/1ps
module tb_du_param_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2, dbg_sel;
    logic [7:0] cmd_imm, mem_wdata, mem_rdata, ir, dbg_data, mem_addr, pc;
    logic       done, err, mem_req, mem_we, mem_ack;
    logic [3:0] flags;

    du_param_core #(.DATA_W(8), .ADDR_W(8), .NREG(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .ir(ir), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    int m_r[4];
    int m_flags, m_pc, m_ir;
    int mem_m[256];

    int lat, got_err, ready_ok;
    bit acked;

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_flags = 0; m_pc = 0; m_ir = 0;
    endtask

    // Arithmetic by integer rules: carry is the sum overflowing 8 bits, V is the true signed result out of range
    task automatic model_alu(input int op, input int a, input int b, input int cin,
                             output int res, output int flg);
        int full, sv, c, v;
        bit arith;
        full = 0; sv = 0;
        arith = (op == 3) || (op == 4) || (op == 13);
        case (op)
            3:  begin full = a + b;       sv = sx(a) + sx(b);       end
            4:  begin full = a - b + 256; sv = sx(a) - sx(b);       end
            13: begin full = a + b + cin; sv = sx(a) + sx(b) + cin; end
            5:  full = a & b;
            6:  full = a | b;
            7:  full = a ^ b;
            default: ;
        endcase
        res = full % 256;
        c   = (arith && full >= 256) ? 1 : 0;
        v   = (arith && (sv > 127 || sv < -128)) ? 1 : 0;
        flg = ((res == 0) ? 8 : 0) + ((res >= 128) ? 4 : 0) + c * 2 + v;
    endtask

    // Issues one command, serves the bus with ack on the k-th request cycle, updates the model
    task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2,
                           input int imm, input int k);
        int a, b, ea, res, flg, req_cyc;
        bit ewe;
        a = m_r[rs1]; b = m_r[rs2];
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 4'(op); cmd_rd = 2'(rd); cmd_rs1 = 2'(rs1);
        cmd_rs2 = 2'(rs2); cmd_imm = 8'(imm);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; req_cyc = 0; acked = 0; ready_ok = 1;
        ea  = (op == 10) ? m_pc : a;
        ewe = (op == 9);
        while (!done && lat < 60) begin
            if (cmd_ready) ready_ok = 0;
            if (mem_req) begin
                req_cyc++;
                if (req_cyc == k) begin
                    chk("bus_addr", mem_addr, ea);
                    chk("bus_we", mem_we, ewe);
                    if (ewe) chk("bus_wdata", mem_wdata, b);
                    mem_rdata = 8'(mem_m[ea]);
                    mem_ack   = 1'b1;
                    acked     = 1;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            lat++;
        end
        chk("done_seen", done, 1);
        if (cmd_ready) ready_ok = 0;
        got_err = err;
        case (op)
            1:  m_r[rd] = a;
            2:  m_r[rd] = imm;
            3, 4, 5, 6, 7, 13: begin
                model_alu(op, a, b, (m_flags >> 1) & 1, res, flg);
                m_r[rd] = res; m_flags = flg;
            end
            8:  if (acked) m_r[rd] = mem_m[a];
            9:  if (acked) mem_m[a] = b;
            10: if (acked) begin m_ir = mem_m[m_pc]; m_pc = (m_pc + 1) % 256; end
            11: m_pc = a;
            12: m_r[rd] = m_flags;
            default: ;
        endcase
        @(negedge clk);
        chk("done_width", done, 0);
    endtask

    task automatic check_model();
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("model_r%0d", i), dbg_data, m_r[i]);
        end
        chk("model_pc", pc, m_pc);
        chk("model_ir", ir, m_ir);
        chk("model_flags", flags, m_flags);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    typedef struct {
        int op, rd, rs1, rs2, imm, k;
        int chk_reg, exp_val, exp_flags, exp_lat, exp_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int seen, op, k, exp_lat;

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm = '0; mem_rdata = '0; mem_ack = 1'b0; dbg_sel = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = $urandom_range(0, 255);

        // Reset asserted mid-cycle
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_flags", flags, 0);
        chk("rst_dbg", dbg_data, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        model_reset();

        //         op  rd rs1 rs2 imm    k  reg  val   flg  lat err
        tbl[0]  = '{2,  1, 0, 0, 'h7F, 1, 1, 'h7F, 'h0, 1, 0};
        tbl[1]  = '{2,  2, 0, 0, 'h01, 1, 2, 'h01, 'h0, 1, 0};
        tbl[2]  = '{3,  3, 1, 2, 0,    1, 3, 'h80, 'h5, 1, 0};
        tbl[3]  = '{2,  1, 0, 0, 'h05, 1, 1, 'h05, 'h5, 1, 0};
        tbl[4]  = '{2,  2, 0, 0, 'h05, 1, 2, 'h05, 'h5, 1, 0};
        tbl[5]  = '{4,  0, 1, 2, 0,    1, 0, 'h00, 'hA, 1, 0};
        tbl[6]  = '{2,  1, 0, 0, 'hFF, 1, 1, 'hFF, 'hA, 1, 0};
        tbl[7]  = '{2,  2, 0, 0, 'h00, 1, 2, 'h00, 'hA, 1, 0};
        tbl[8]  = '{13, 0, 1, 2, 0,    1, 0, 'h00, 'hA, 1, 0};
        tbl[9]  = '{12, 3, 0, 0, 0,    1, 3, 'h0A, 'hA, 1, 0};
        tbl[10] = '{15, 3, 0, 1, 'h55, 1, 3, 'h0A, 'hA, 1, 1};
        tbl[11] = '{7,  2, 1, 3, 0,    1, 2, 'hF5, 'h4, 1, 0};
        tbl[12] = '{14, 2, 1, 1, 0,    1, 2, 'hF5, 'h4, 1, 1};

        for (int i = 0; i < 13; i++) begin
            run_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].k);
            dbg_sel = 2'(tbl[i].chk_reg);
            #1;
            chk($sformatf("vec%0d_reg", i), dbg_data, tbl[i].exp_val);
            chk($sformatf("vec%0d_flags", i), flags, tbl[i].exp_flags);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_err", i), got_err, tbl[i].exp_err);
            @(negedge clk);
        end
        check_model();

        // FETCH with ack on the third request cycle
        do_reset();
        mem_m[0] = 'hA5;
        run_cmd(10, 0, 0, 0, 0, 3);
        chk("fetch_lat", lat, 4);
        chk("fetch_ir", ir, 'hA5);
        chk("fetch_pc", pc, 1);
        chk("fetch_ready_low", ready_ok, 1);
        chk("fetch_err", got_err, 0);

        // STORE interrupted by reset before ack
        run_cmd(2, 1, 0, 0, 'h10, 1);
        run_cmd(2, 2, 0, 0, 'h3C, 1);
        cmd_valid = 1'b1; cmd_op = 4'd9; cmd_rd = 2'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("store_req", mem_req, 1);
        chk("store_addr", mem_addr, 'h10);
        chk("store_we", mem_we, 1);
        chk("store_wdata", mem_wdata, 'h3C);
        #2 rst = 1'b1;
        #1;
        chk("store_rst_req", mem_req, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("store_rst_no_done", seen, 0);
        chk("store_rst_ready", cmd_ready, 1);
        model_reset();
        check_model();

        // Long ack delay: watchdog fires when enabled, otherwise the core keeps waiting
        run_cmd(2, 1, 0, 0, 'h20, 1);
        run_cmd(2, 0, 0, 0, 'h77, 1);
        mem_m['h20] = 'h99;
        run_cmd(8, 0, 1, 0, 0, 40);
        dbg_sel = 2'd0;
        #1;
`ifdef DU_BUS_TIMEOUT_EN
        chk("tmo_lat", lat, 17);
        chk("tmo_err", got_err, 1);
        chk("tmo_reg", dbg_data, 'h77);
`else
        chk("slow_lat", lat, 41);
        chk("slow_err", got_err, 0);
        chk("slow_reg", dbg_data, 'h99);
`endif
        @(negedge clk);
        check_model();

        // Randomised commands against the reference model
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 15);
            k  = $urandom_range(1, 4);
            run_cmd(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 255), k);
            exp_lat = (op >= 8 && op <= 10) ? k + 1 : 1;
            chk($sformatf("rnd%0d_lat", n), lat, exp_lat);
            chk($sformatf("rnd%0d_err", n), got_err, (op >= 14) ? 1 : 0);
            chk($sformatf("rnd%0d_ready_low", n), ready_ok, 1);
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
